// File: rtl/mole_pkg.sv
// Shared types and width helpers for the whack-a-mole round sequencer.
package mole_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SPAWN = 3'd1,
      SHOW  = 3'd2,
      GAP   = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int SECS_W = 7;

   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Bits needed to hold the values 0..max_val inclusive.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mole_round_ctrl_tick_downcounter.sv
// Loadable, enable-gated down-counter with zero flag; stops at zero.
module tick_downcounter #(
   parameter int           W         = 8,
   parameter logic [W-1:0] RESET_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         zero
);

   always_ff @(posedge clk) begin
      if (reset)
         count <= RESET_VAL;
      else if (load)
         count <= load_val;
      else if (en && (count != '0))
         count <= count - W'(1);
   end

   assign zero = (count == '0);

endmodule

// File: rtl/mole_round_ctrl.sv
// Round sequencer: round timer, mole spawn/show/gap timing and scoring.
//
//  state | meaning
//  IDLE  | waiting for start, score of last round shown
//  SPAWN | one cycle: pick next mole, load mole timer
//  SHOW  | mole lit until correct hit or mole timer runs out
//  GAP   | no mole lit until gap timer runs out
//  DONE  | round expired, game_over high, waiting for start
module mole_round_ctrl
   import mole_pkg::*;
#(
   parameter int  NUM_MOLES     = 8,
   parameter int  GAME_SECONDS  = 60,
   parameter int  TICKS_PER_SEC = 100,
   parameter int  MOLE_TICKS    = 20,
   parameter int  GAP_TICKS     = 10,
   parameter int  SCORE_BITS    = 8,
   localparam int IDX_W         = idx_width(NUM_MOLES)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tick_in,
   input  logic                  start,
   input  logic [IDX_W-1:0]      rand_idx,
   input  logic [NUM_MOLES-1:0]  hit,
   output logic [NUM_MOLES-1:0]  mole_mask,
   output logic [SCORE_BITS-1:0] score,
   output logic [SECS_W-1:0]     seconds_left,
   output logic [2:0]            state,
   output logic                  game_over
);

   localparam int PRE_W  = cnt_width(TICKS_PER_SEC);
   localparam int MOLE_W = cnt_width(MOLE_TICKS);
   localparam int GAP_W  = cnt_width(GAP_TICKS);

   state_t state_q, state_n;

   logic [IDX_W-1:0]     mole_idx, idx_sel, show_idx;
   logic [NUM_MOLES-1:0] mask_n;

   logic [PRE_W-1:0]  pre_cnt;
   logic [MOLE_W-1:0] mole_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic              pre_zero, mole_zero, gap_zero, sec_zero;

   logic pre_load, pre_en, sec_load, sec_en;
   logic mole_load, mole_en, gap_load, gap_en;
   logic score_clr, score_inc;
   logic round_tick, pre_wrap, expire, correct_hit;

   logic unused_flags;
   assign unused_flags = mole_zero ^ gap_zero ^ sec_zero;

   assign round_tick  = tick_in && (state_q inside {SPAWN, SHOW, GAP});
   // A zero prescaler is treated as a wrap so the round can never stall.
   assign pre_wrap    = round_tick && ((pre_cnt == PRE_W'(1)) || pre_zero);
   assign expire      = pre_wrap && (seconds_left == SECS_W'(1));
   assign correct_hit = (state_q == SHOW) && hit[mole_idx];
   assign idx_sel     = (rand_idx == mole_idx) ? rand_idx + IDX_W'(1) : rand_idx;
   assign show_idx    = (state_q == SPAWN) ? idx_sel : mole_idx;

   always_comb begin
      state_n   = state_q;
      pre_load  = 1'b0;
      pre_en    = 1'b0;
      sec_load  = 1'b0;
      sec_en    = 1'b0;
      mole_load = 1'b0;
      mole_en   = 1'b0;
      gap_load  = 1'b0;
      gap_en    = 1'b0;
      score_clr = 1'b0;
      score_inc = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_n   = SPAWN;
               pre_load  = 1'b1;
               sec_load  = 1'b1;
               score_clr = 1'b1;
            end
         end
         SPAWN: begin
            state_n   = SHOW;
            mole_load = 1'b1;
         end
         SHOW: begin
            mole_en = tick_in;
            if (correct_hit) begin
               score_inc = 1'b1;
               state_n   = GAP;
               gap_load  = 1'b1;
            end else if (tick_in && (mole_cnt == MOLE_W'(1))) begin
               state_n  = GAP;
               gap_load = 1'b1;
            end
         end
         GAP: begin
            gap_en = tick_in;
            if (tick_in && (gap_cnt == GAP_W'(1)))
               state_n = SPAWN;
         end
         default: state_n = IDLE;
      endcase

      if (round_tick) begin
         if (pre_wrap) begin
            pre_load = 1'b1;
            sec_en   = 1'b1;
         end else begin
            pre_en = 1'b1;
         end
      end

      // Round expiry overrides any SHOW/GAP transition; a hit still scores.
      if (expire)
         state_n = DONE;
   end

   always_comb begin
      mask_n = '0;
      if (state_n == SHOW)
         mask_n[show_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         mole_idx  <= '0;
         score     <= '0;
         mole_mask <= '0;
         game_over <= 1'b0;
      end else begin
         state_q   <= state_n;
         mole_mask <= mask_n;
         game_over <= (state_n == DONE);
         if (state_q == SPAWN)
            mole_idx <= idx_sel;
         if (score_clr)
            score <= '0;
         else if (score_inc && (score != '1))
            score <= score + SCORE_BITS'(1);
      end
   end

   assign state = state_q;

   tick_downcounter #(.W(PRE_W), .RESET_VAL('0)) u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .load     (pre_load),
      .load_val (PRE_W'(TICKS_PER_SEC)),
      .en       (pre_en),
      .count    (pre_cnt),
      .zero     (pre_zero)
   );

   tick_downcounter #(.W(SECS_W), .RESET_VAL(SECS_W'(GAME_SECONDS))) u_seconds (
      .clk      (clk),
      .reset    (reset),
      .load     (sec_load),
      .load_val (SECS_W'(GAME_SECONDS)),
      .en       (sec_en),
      .count    (seconds_left),
      .zero     (sec_zero)
   );

   tick_downcounter #(.W(MOLE_W), .RESET_VAL('0)) u_mole_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (mole_load),
      .load_val (MOLE_W'(MOLE_TICKS)),
      .en       (mole_en),
      .count    (mole_cnt),
      .zero     (mole_zero)
   );

   tick_downcounter #(.W(GAP_W), .RESET_VAL('0)) u_gap_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (gap_load),
      .load_val (GAP_W'(GAP_TICKS)),
      .en       (gap_en),
      .count    (gap_cnt),
      .zero     (gap_zero)
   );

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Scoreboard bench: two sequencer instances (3 s / 8-bit score, 10 s / 2-bit score) on shared stimulus.
module tb_mole_round_ctrl;

   localparam int N    = 8;
   localparam int TPS  = 4;
   localparam int MOLE = 5;
   localparam int GAPT = 2;

   localparam int P_IDLE  = 0;
   localparam int P_SPAWN = 1;
   localparam int P_SHOW  = 2;
   localparam int P_GAP   = 3;
   localparam int P_DONE  = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick_in = 1'b0;
   logic       start = 1'b0;
   logic [2:0] rand_idx = '0;
   logic [7:0] hit = '0;

   logic [7:0] mask0, mask1;
   logic [7:0] score0;
   logic [1:0] score1;
   logic [6:0] secs0, secs1;
   logic [2:0] st0, st1;
   logic       go0, go1;

   always #5 clk = ~clk;

   mole_round_ctrl #(
      .NUM_MOLES(N), .GAME_SECONDS(3), .TICKS_PER_SEC(TPS),
      .MOLE_TICKS(MOLE), .GAP_TICKS(GAPT), .SCORE_BITS(8)
   ) dut0 (
      .clk(clk), .reset(reset), .tick_in(tick_in), .start(start),
      .rand_idx(rand_idx), .hit(hit), .mole_mask(mask0), .score(score0),
      .seconds_left(secs0), .state(st0), .game_over(go0)
   );

   mole_round_ctrl #(
      .NUM_MOLES(N), .GAME_SECONDS(10), .TICKS_PER_SEC(TPS),
      .MOLE_TICKS(MOLE), .GAP_TICKS(GAPT), .SCORE_BITS(2)
   ) dut1 (
      .clk(clk), .reset(reset), .tick_in(tick_in), .start(start),
      .rand_idx(rand_idx), .hit(hit), .mole_mask(mask1), .score(score1),
      .seconds_left(secs1), .state(st1), .game_over(go1)
   );

   typedef struct {
      int st;
      int mask;
      int score;
      int secs;
      int go;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // Reference model: per-instance round progress kept as plain tallies.
   int m_gsec[2] = '{3, 10};
   int m_smax[2] = '{255, 3};
   int m_ph[2]   = '{P_IDLE, P_IDLE};
   int m_sc[2]   = '{0, 0};
   int m_rt[2]   = '{0, 0};   // ticks played this round
   int m_last[2] = '{0, 0};   // mole currently/last shown
   int m_ms[2]   = '{0, 0};   // ticks the current mole has been up
   int m_gs[2]   = '{0, 0};   // ticks spent in the current gap

   function automatic bit is_play(input int ph);
      return (ph == P_SPAWN) || (ph == P_SHOW) || (ph == P_GAP);
   endfunction

   task automatic model_step(input int i, input bit r, input bit s, input bit t,
                             input int ridx, input int h);
      int old;
      exp_t e;
      old = m_ph[i];
      if (r) begin
         m_ph[i] = P_IDLE; m_sc[i] = 0; m_rt[i] = 0; m_last[i] = 0;
         m_ms[i] = 0; m_gs[i] = 0;
      end else begin
         case (old)
            P_IDLE, P_DONE:
               if (s) begin
                  m_ph[i] = P_SPAWN; m_sc[i] = 0; m_rt[i] = 0;
               end
            P_SPAWN: begin
               m_last[i] = (ridx == m_last[i]) ? (ridx + 1) % N : ridx;
               m_ph[i] = P_SHOW;
               m_ms[i] = 0;
            end
            P_SHOW:
               if (((h >> m_last[i]) & 1) == 1) begin
                  if (m_sc[i] < m_smax[i]) m_sc[i] = m_sc[i] + 1;
                  m_ph[i] = P_GAP; m_gs[i] = 0;
               end else if (t) begin
                  m_ms[i] = m_ms[i] + 1;
                  if (m_ms[i] == MOLE) begin
                     m_ph[i] = P_GAP; m_gs[i] = 0;
                  end
               end
            P_GAP:
               if (t) begin
                  m_gs[i] = m_gs[i] + 1;
                  if (m_gs[i] == GAPT) m_ph[i] = P_SPAWN;
               end
            default: ;
         endcase
         if (is_play(old) && t) begin
            m_rt[i] = m_rt[i] + 1;
            if (m_rt[i] == m_gsec[i] * TPS) m_ph[i] = P_DONE;
         end
      end
      e.st    = m_ph[i];
      e.mask  = (m_ph[i] == P_SHOW) ? (1 << m_last[i]) : 0;
      e.score = m_sc[i];
      e.secs  = m_gsec[i] - m_rt[i] / TPS;
      e.go    = (m_ph[i] == P_DONE) ? 1 : 0;
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // mode 0: random hits; 1: always hit lit moles; 2: hit lit mole only on the
   // round-expiring tick; 3: only stray hit[2] presses.
   task automatic step(input bit r, input bit s, input int ridx_fixed, input int mode);
      int h;
      int aim;
      bit t;
      @(negedge clk);
      #1;
      t = (cyc % 3 == 0);
      cyc++;
      tick_in  = t;
      reset    = r;
      start    = s;
      rand_idx = (ridx_fixed < 0) ? 3'($urandom_range(N - 1)) : 3'(ridx_fixed);
      aim = 0;
      for (int i = 0; i < 2; i++)
         if (m_ph[i] == P_SHOW) aim |= (1 << m_last[i]);
      h = 0;
      case (mode)
         0: begin
            case ($urandom_range(3))
               0: h = aim;
               1: h = 1 << $urandom_range(N - 1);
               default: h = 0;
            endcase
         end
         1: h = aim;
         2: begin
            for (int i = 0; i < 2; i++)
               if (m_ph[i] == P_SHOW && t && (m_rt[i] + 1 == m_gsec[i] * TPS))
                  h |= (1 << m_last[i]);
            if (h == 0 && $urandom_range(3) == 0) h = 8'h04;
         end
         default: if ($urandom_range(2) == 0) h = 8'h04;
      endcase
      hit = 8'(h);
      model_step(0, r, s, t, int'(rand_idx), h);
      model_step(1, r, s, t, int'(rand_idx), h);
   endtask

   task automatic check(input int i, input exp_t e, input logic [2:0] st,
                        input logic [7:0] mk, input logic [7:0] sc,
                        input logic [6:0] se, input logic go);
      vectors++;
      if (st !== 3'(e.st) || mk !== 8'(e.mask) || sc !== 8'(e.score) ||
          se !== 7'(e.secs) || go !== 1'(e.go)) begin
         miscompares++;
         $display("FAIL inst%0d cyc%0d: state=%0d/%0d mask=%h/%h score=%0d/%0d secs=%0d/%0d game_over=%0d/%0d (actual/expected)",
                  i, cyc, st, e.st, mk, 8'(e.mask), sc, e.score, se, e.secs, go, e.go);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         check(0, e, st0, mask0, score0, secs0, go0);
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         check(1, e, st1, mask1, {6'b0, score1}, secs1, go1);
      end
   end

   initial begin
      repeat (3) step(1, 0, -1, 3);
      repeat (20) step(0, 0, -1, 0);

      // First mole at index 5, hit four clocks after start.
      step(0, 1, 5, 3);
      repeat (3) step(0, 0, 5, 3);
      step(0, 0, 5, 1);
      repeat (4) step(0, 0, 5, 3);

      // Unhit moles with stray hit[2]; rand_idx stuck at 3 forces the repeat bump.
      repeat (130) step(0, 0, 3, 3);

      // Rounds from DONE, aiming a hit at the expiring tick.
      for (int k = 0; k < 4; k++) begin
         step(0, 1, -1, 2);
         repeat (125 + k) step(0, 0, -1, 2);
      end

      // Fast correct hits: 2-bit instance saturates.
      step(0, 1, -1, 1);
      repeat (130) step(0, 0, -1, 1);

      // Reset while a mole is shown with a nonzero score.
      step(0, 1, -1, 1);
      for (int k = 0; k < 40 && !(m_ph[0] == P_SHOW && m_sc[0] >= 3); k++)
         step(0, 0, -1, 1);
      step(1, 0, -1, 0);
      repeat (5) step(0, 0, -1, 0);

      // Random soak with occasional start and reset.
      for (int k = 0; k < 2000; k++)
         step($urandom_range(499) == 0, $urandom_range(39) == 0, -1, 0);

      @(negedge clk);
      #2;
      vectors++;
      if (q0.size() != 0 || q1.size() != 0) begin
         miscompares++;
         $display("FAIL drain: pending=%0d/%0d required=0/0", q0.size(), q1.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
